// File: rtl/msrh_csu_issue_unit.sv
// msrh_csu_issue_unit: in-order, serializing issue queue for CSR/system instructions.
// Issues at most one instruction at a time, always the oldest, and holds everything else
// back until the CSU pipe reports completion of that instruction.
//
// Ports:
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   i_disp_valid       dispatch request; o_disp_ready when a slot is free
//   i_disp_issue       dispatched instruction with initial operand readiness
//   i_phy_wr           physical write bus used for operand wakeup
//   o_issue            registered issue payload to the pipe (.valid is a 1-cycle pulse)
//   o_issue_index      one-hot slot of the issued entry
//   i_done             completion from the pipe, i_done_index is its one-hot slot
//   i_flush            drops every entry and any same-cycle dispatch/done
//   o_empty, o_busy    no valid entries / an entry is waiting for its done

package msrh_pkg;
    localparam int TGT_BUS_SIZE = 2;
    localparam int RNID_W       = 6;

    typedef enum logic [1:0] {GPR = 2'd0, FPR = 2'd1} reg_t;

    typedef struct packed {
        logic              valid;
        reg_t              typ;
        logic [RNID_W-1:0] rnid;
        logic              ready;
    } reg_rd_issue_t;

    typedef struct packed {
        logic                valid;
        logic [31:0]         inst;
        reg_rd_issue_t [1:0] rd_regs;
    } issue_t;

    typedef struct packed {
        logic              valid;
        reg_t              rd_type;
        logic [RNID_W-1:0] rd_rnid;
    } phy_wr_t;
endpackage

module msrh_csu_issue_unit #(
    parameter int unsigned ENTRY_SIZE = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_disp_valid,
    output logic                    o_disp_ready,
    input  msrh_pkg::issue_t        i_disp_issue,
    input  msrh_pkg::phy_wr_t       i_phy_wr [msrh_pkg::TGT_BUS_SIZE],
    output msrh_pkg::issue_t        o_issue,
    output logic [ENTRY_SIZE-1:0]   o_issue_index,
    input  logic                    i_done,
    input  logic [ENTRY_SIZE-1:0]   i_done_index,
    input  logic                    i_flush,
    output logic                    o_empty,
    output logic                    o_busy
);
    localparam int unsigned IDX_W = $clog2(ENTRY_SIZE);

    typedef enum logic [1:0] {StInvalid, StWait, StIssued} state_t;

    state_t                state_q [ENTRY_SIZE];
    state_t                state_d [ENTRY_SIZE];
    msrh_pkg::issue_t      entry_q [ENTRY_SIZE];
    msrh_pkg::issue_t      entry_d [ENTRY_SIZE];
    logic [IDX_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]        count_q, count_d;
    msrh_pkg::issue_t      issue_q, issue_d;
    logic [ENTRY_SIZE-1:0] issue_index_q, issue_index_d;

    logic [ENTRY_SIZE-1:0] head_oh;
    logic                  head_ready;
    logic                  busy;
    logic                  issue_fire, done_fire, disp_fire;
    msrh_pkg::issue_t      disp_entry;

    assign o_disp_ready  = (count_q != (IDX_W+1)'(ENTRY_SIZE));
    assign o_empty       = (count_q == '0);
    assign o_busy        = busy;
    assign o_issue       = issue_q;
    assign o_issue_index = issue_index_q;

    always_comb begin
        head_oh          = '0;
        head_oh[head_q]  = 1'b1;

        busy = 1'b0;
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            if (state_q[i] == StIssued) busy = 1'b1;
        end

        head_ready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            if (!entry_q[head_q].rd_regs[s].ready) head_ready = 1'b0;
        end

        issue_fire = (state_q[head_q] == StWait) && head_ready && !busy && !i_flush;
        done_fire  = i_done && !i_flush && (state_q[head_q] == StIssued) &&
                     (i_done_index == head_oh);
        disp_fire  = i_disp_valid && o_disp_ready && !i_flush;

        // Incoming operands are ready if already marked, unused, GPR x0, or woken this cycle.
        disp_entry = i_disp_issue;
        for (int s = 0; s < 2; s++) begin
            if (!i_disp_issue.rd_regs[s].valid ||
                (i_disp_issue.rd_regs[s].typ == msrh_pkg::GPR &&
                 i_disp_issue.rd_regs[s].rnid == '0)) begin
                disp_entry.rd_regs[s].ready = 1'b1;
            end
            for (int k = 0; k < msrh_pkg::TGT_BUS_SIZE; k++) begin
                if (i_phy_wr[k].valid &&
                    i_phy_wr[k].rd_type == i_disp_issue.rd_regs[s].typ &&
                    i_phy_wr[k].rd_rnid == i_disp_issue.rd_regs[s].rnid) begin
                    disp_entry.rd_regs[s].ready = 1'b1;
                end
            end
        end

        state_d       = state_q;
        entry_d       = entry_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        issue_d       = '0;
        issue_index_d = '0;

        // Wakeup of waiting entries; ready bits are sticky until the slot is freed.
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            if (state_q[i] == StWait) begin
                for (int s = 0; s < 2; s++) begin
                    for (int k = 0; k < msrh_pkg::TGT_BUS_SIZE; k++) begin
                        if (i_phy_wr[k].valid &&
                            i_phy_wr[k].rd_type == entry_q[i].rd_regs[s].typ &&
                            i_phy_wr[k].rd_rnid == entry_q[i].rd_regs[s].rnid) begin
                            entry_d[i].rd_regs[s].ready = 1'b1;
                        end
                    end
                end
            end
        end

        if (issue_fire) begin
            state_d[head_q] = StIssued;
            issue_d         = entry_q[head_q];
            issue_d.valid   = 1'b1;
            issue_index_d   = head_oh;
        end

        // issue_fire needs !busy while done_fire needs the head ISSUED, so they never overlap.
        if (done_fire) begin
            state_d[head_q] = StInvalid;
            head_d          = head_q + IDX_W'(1);
        end

        // A dispatch can only target the head slot when the queue is empty, so no clash with done.
        if (disp_fire) begin
            state_d[tail_q] = StWait;
            entry_d[tail_q] = disp_entry;
            tail_d          = tail_q + IDX_W'(1);
        end

        count_d = count_q + (IDX_W+1)'(disp_fire) - (IDX_W+1)'(done_fire);

        if (i_flush) begin
            for (int i = 0; i < ENTRY_SIZE; i++) state_d[i] = StInvalid;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < ENTRY_SIZE; i++) begin
                state_q[i] <= StInvalid;
                entry_q[i] <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            issue_q       <= '0;
            issue_index_q <= '0;
        end else begin
            for (int i = 0; i < ENTRY_SIZE; i++) begin
                state_q[i] <= state_d[i];
                entry_q[i] <= entry_d[i];
            end
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            issue_q       <= issue_d;
            issue_index_q <= issue_index_d;
        end
    end

endmodule

// File: tb/tb_msrh_csu_issue_unit.sv
// Directed bench for msrh_csu_issue_unit: dispatch/issue/done, full queue,
// wakeup, flush with stale done, and in-order blocking.
module tb_msrh_csu_issue_unit;
    logic                   i_clk;
    logic                   i_reset_n;
    logic                   i_disp_valid;
    logic                   o_disp_ready;
    msrh_pkg::issue_t       i_disp_issue;
    msrh_pkg::phy_wr_t      i_phy_wr [msrh_pkg::TGT_BUS_SIZE];
    msrh_pkg::issue_t       o_issue;
    logic [3:0]             o_issue_index;
    logic                   i_done;
    logic [3:0]             i_done_index;
    logic                   i_flush;
    logic                   o_empty;
    logic                   o_busy;

    int n_checks = 0;
    int n_pass   = 0;

    msrh_csu_issue_unit #(.ENTRY_SIZE(4)) u_dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_disp_valid  (i_disp_valid),
        .o_disp_ready  (o_disp_ready),
        .i_disp_issue  (i_disp_issue),
        .i_phy_wr      (i_phy_wr),
        .o_issue       (o_issue),
        .o_issue_index (o_issue_index),
        .i_done        (i_done),
        .i_done_index  (i_done_index),
        .i_flush       (i_flush),
        .o_empty       (o_empty),
        .o_busy        (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic msrh_pkg::issue_t mk(input logic [31:0] inst, input msrh_pkg::reg_t typ,
                                            input logic [5:0] rnid, input logic rdy);
        msrh_pkg::issue_t x;
        x                  = '0;
        x.valid            = 1'b1;
        x.inst             = inst;
        x.rd_regs[0].valid = 1'b1;
        x.rd_regs[0].typ   = typ;
        x.rd_regs[0].rnid  = rnid;
        x.rd_regs[0].ready = rdy;
        return x;
    endfunction

    task automatic disp(input msrh_pkg::issue_t x);
        i_disp_valid = 1'b1;
        i_disp_issue = x;
        tick();
        i_disp_valid = 1'b0;
    endtask

    task automatic done(input logic [3:0] idx);
        i_done       = 1'b1;
        i_done_index = idx;
        tick();
        i_done       = 1'b0;
    endtask

    task automatic wake(input int k, input msrh_pkg::reg_t typ, input logic [5:0] rnid);
        i_phy_wr[k].valid   = 1'b1;
        i_phy_wr[k].rd_type = typ;
        i_phy_wr[k].rd_rnid = rnid;
        tick();
        i_phy_wr[k].valid   = 1'b0;
    endtask

    task automatic expect_issue(input string tag, input logic [3:0] idx, input logic [31:0] inst);
        check({tag, ".valid"}, 64'(o_issue.valid), 64'd1);
        check({tag, ".index"}, 64'(o_issue_index), 64'(idx));
        check({tag, ".inst"},  64'(o_issue.inst),  64'(inst));
    endtask

    initial begin
        i_reset_n    = 1'b0;
        i_disp_valid = 1'b0;
        i_disp_issue = '0;
        i_done       = 1'b0;
        i_done_index = '0;
        i_flush      = 1'b0;
        for (int k = 0; k < msrh_pkg::TGT_BUS_SIZE; k++) i_phy_wr[k] = '0;
        #12;
        check("rst.disp_ready", 64'(o_disp_ready), 64'd1);
        check("rst.empty",      64'(o_empty),      64'd1);
        check("rst.busy",       64'(o_busy),       64'd0);
        check("rst.issue",      64'(o_issue),      64'd0);
        check("rst.index",      64'(o_issue_index), 64'd0);
        i_reset_n = 1'b1;
        tick();

        // Single CSRRW with rs1 ready
        disp(mk(32'h0000_1073, msrh_pkg::GPR, 6'd5, 1'b1));
        check("s1.no_issue_yet", 64'(o_issue.valid), 64'd0);
        check("s1.not_empty",    64'(o_empty),       64'd0);
        tick();
        expect_issue("s1.issue", 4'b0001, 32'h0000_1073);
        tick();
        check("s1.pulse", 64'(o_issue.valid), 64'd0);
        check("s1.busy",  64'(o_busy),        64'd1);
        done(4'b0001);
        check("s1.empty", 64'(o_empty), 64'd1);
        check("s1.idle",  64'(o_busy),  64'd0);

        // Four back-to-back into slots 1,2,3,0; only the first issues
        disp(mk(32'h10, msrh_pkg::GPR, 6'd1, 1'b1));
        check("s2.t0", 64'(o_issue.valid), 64'd0);
        disp(mk(32'h11, msrh_pkg::GPR, 6'd1, 1'b1));
        expect_issue("s2.first", 4'b0010, 32'h10);
        disp(mk(32'h12, msrh_pkg::GPR, 6'd1, 1'b1));
        check("s2.t2", 64'(o_issue.valid), 64'd0);
        disp(mk(32'h13, msrh_pkg::GPR, 6'd1, 1'b1));
        check("s2.t3",   64'(o_issue.valid), 64'd0);
        check("s2.full", 64'(o_disp_ready),  64'd0);
        check("s2.busy", 64'(o_busy),        64'd1);
        i_disp_valid = 1'b1;
        i_disp_issue = mk(32'h99, msrh_pkg::GPR, 6'd1, 1'b1);
        tick();
        check("s2.still_full", 64'(o_disp_ready),  64'd0);
        check("s2.no_reissue", 64'(o_issue.valid), 64'd0);
        // Done on the head while full: the dispatch is refused (ready was low)
        i_done       = 1'b1;
        i_done_index = 4'b0010;
        tick();
        i_done       = 1'b0;
        i_disp_valid = 1'b0;
        check("s2.freed",    64'(o_disp_ready),  64'd1);
        check("s2.gap",      64'(o_issue.valid), 64'd0);
        tick();
        expect_issue("s2.second", 4'b0100, 32'h11);
        tick();
        // Simultaneous dispatch and done: count stays at 3
        i_done       = 1'b1;
        i_done_index = 4'b0100;
        disp(mk(32'h20, msrh_pkg::GPR, 6'd1, 1'b1));
        i_done       = 1'b0;
        check("s2.cnt3", 64'(o_disp_ready), 64'd1);
        tick();
        expect_issue("s2.third", 4'b1000, 32'h12);
        done(4'b1000);
        tick();
        expect_issue("s2.fourth", 4'b0001, 32'h13);
        done(4'b0001);
        tick();
        expect_issue("s2.wrapped", 4'b0010, 32'h20);
        done(4'b0010);
        check("s2.drained", 64'(o_empty), 64'd1);

        // Wakeup: slot 2 waits on GPR 0x12
        disp(mk(32'h30, msrh_pkg::GPR, 6'h12, 1'b0));
        tick();
        check("s3.wait", 64'(o_issue.valid), 64'd0);
        wake(0, msrh_pkg::GPR, 6'h13);
        tick();
        check("s3.wrong_rnid", 64'(o_issue.valid), 64'd0);
        wake(1, msrh_pkg::FPR, 6'h12);
        tick();
        check("s3.wrong_type", 64'(o_issue.valid), 64'd0);
        wake(1, msrh_pkg::GPR, 6'h12);
        check("s3.wake_edge", 64'(o_issue.valid), 64'd0);
        tick();
        expect_issue("s3.issue", 4'b0100, 32'h30);
        done(4'b0100);

        // Walk head to slot 1, issue there, then flush
        disp(mk(32'h40, msrh_pkg::GPR, 6'd1, 1'b1));
        tick();
        expect_issue("s5.e", 4'b1000, 32'h40);
        done(4'b1000);
        disp(mk(32'h41, msrh_pkg::GPR, 6'd1, 1'b1));
        tick();
        done(4'b0001);
        disp(mk(32'h42, msrh_pkg::GPR, 6'd1, 1'b1));
        tick();
        expect_issue("s5.g", 4'b0010, 32'h42);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("s5.flush_empty", 64'(o_empty),       64'd1);
        check("s5.flush_busy",  64'(o_busy),        64'd0);
        check("s5.flush_issue", 64'(o_issue.valid), 64'd0);
        done(4'b0010);
        check("s5.stale_done", 64'(o_empty),      64'd1);
        check("s5.stale_rdy",  64'(o_disp_ready), 64'd1);
        // GPR x0 source is implicitly ready
        disp(mk(32'h50, msrh_pkg::GPR, 6'd0, 1'b0));
        tick();
        expect_issue("s5.slot0", 4'b0001, 32'h50);
        done(4'b0001);
        // Dispatch alongside flush is dropped
        i_flush = 1'b1;
        disp(mk(32'h51, msrh_pkg::GPR, 6'd1, 1'b1));
        i_flush = 1'b0;
        check("s5.flush_drop", 64'(o_empty), 64'd1);
        tick();
        check("s5.flush_noissue", 64'(o_issue.valid), 64'd0);

        // In-order: slot 0 waits on FPR 7, slot 1 ready
        disp(mk(32'h60, msrh_pkg::FPR, 6'd7, 1'b0));
        disp(mk(32'h61, msrh_pkg::GPR, 6'd1, 1'b1));
        tick();
        tick();
        check("s6.blocked", 64'(o_issue.valid), 64'd0);
        wake(0, msrh_pkg::FPR, 6'd7);
        tick();
        expect_issue("s6.first", 4'b0001, 32'h60);
        tick();
        check("s6.serial", 64'(o_issue.valid), 64'd0);
        done(4'b0001);
        tick();
        expect_issue("s6.second", 4'b0010, 32'h61);
        done(4'b0010);
        check("s6.empty", 64'(o_empty), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
